work_packet_tx: RTL and testbench

- UART transmitter for complete 512-bit mining jobs. It is the transmit-side counterpart of the job receiver in serial_core.
- It serialises {midstate, data2} as 64 bytes of 8N1 on the comm clock domain.
- Uses: forwarding work to a downstream FPGA in a chain, and host-side/loopback job injection for bench and board test.
- The wire format is byte-for-byte what serial_core reassembles into midstate/data2.

---
 rtl/work_packet_tx.sv | 144 ++++++++++++++
 tb/tb_work_packet_tx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/work_packet_tx.sv
// 8N1 UART transmitter for a complete 512-bit mining job {midstate, data2}.
// The job goes out as 64 bytes, byte 0 (data2[7:0]) first and LSB first within each byte.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle high, waiting for load
// S_START | start bit (tx=0) of byte byte_idx
// S_DATA  | data bit bit_cnt of byte byte_idx, LSB first
// S_STOP  | stop bit (tx=1)
// S_GAP   | optional idle-high bit periods after the stop bit
module work_packet_tx #(
    parameter int CLOCK    = 25000000,
    parameter int BAUD     = 115200,
    parameter int GAP_BITS = 0,
    parameter int BYTES    = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [255:0] midstate,
    input  logic [255:0] data2,
    output logic         tx,
    output logic         busy,
    output logic         done,
    output logic [6:0]   byte_idx
);

    localparam int BIT_CYCLES = CLOCK / BAUD;
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] BAUD_RELOAD = CW'(BIT_CYCLES - 1);
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [6:0] LAST_BYTE = 7'(BYTES - 1);

    generate
        if (BIT_CYCLES < 2) begin : g_bad_bit_cycles
            $error("work_packet_tx: CLOCK/BAUD must be at least 2 clock cycles per bit");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    state_t          state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [7:0]      shift;
    logic [511:0]    payload;
    logic [6:0]      byte_nxt;
    logic [7:0]      next_byte;
    logic            byte_end;

    // Byte selection straight out of the latched payload; no wide shifter needed.
    assign byte_nxt  = byte_idx + 7'd1;
    assign next_byte = payload[{byte_nxt[5:0], 3'b000} +: 8];
    assign byte_end  = (state == S_STOP && GAP_BITS == 0) ||
                       (state == S_GAP && gap_cnt == GAP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            byte_idx <= 7'd0;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            gap_cnt  <= '0;
            shift    <= 8'd0;
            payload  <= '0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                tx       <= 1'b1;
                busy     <= 1'b0;
                byte_idx <= 7'd0;
                if (load) begin
                    payload  <= {midstate, data2};
                    shift    <= data2[7:0];
                    state    <= S_START;
                    tx       <= 1'b0;
                    busy     <= 1'b1;
                    baud_cnt <= BAUD_RELOAD;
                end
            end else if (baud_cnt != '0) begin
                baud_cnt <= baud_cnt - CW'(1);
            end else begin
                // Bit boundary: every bit period is reloaded from the same constant.
                baud_cnt <= BAUD_RELOAD;
                if (byte_end) begin
                    if (byte_idx == LAST_BYTE) begin
                        state    <= S_IDLE;
                        tx       <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        byte_idx <= 7'd0;
                    end else begin
                        byte_idx <= byte_nxt;
                        shift    <= next_byte;
                        state    <= S_START;
                        tx       <= 1'b0;
                    end
                end else begin
                    case (state)
                        S_START: begin
                            state   <= S_DATA;
                            bit_cnt <= 3'd0;
                            tx      <= shift[0];
                        end
                        S_DATA: begin
                            if (bit_cnt == 3'd7) begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end else begin
                                shift   <= {1'b0, shift[7:1]};
                                bit_cnt <= bit_cnt + 3'd1;
                                tx      <= shift[1];
                            end
                        end
                        S_STOP: begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                            tx      <= 1'b1;
                        end
                        S_GAP: begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                        default: begin
                            state <= S_IDLE;
                            tx    <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_work_packet_tx.sv
// Bench for work_packet_tx: fixed single-byte frame table plus full random packets
// checked cycle by cycle against an arithmetic model of the wire format.
module tb_work_packet_tx;

    localparam int BC = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst0 = 1'b0, load0 = 1'b0;
    logic [255:0] mid0 = '0, d20 = '0;
    logic         tx0, busy0, done0;
    logic [6:0]   bi0;

    logic         rstg = 1'b0, loadg = 1'b0;
    logic [255:0] midg = '0, d2g = '0;
    logic         txg, busyg, doneg;
    logic [6:0]   big;

    work_packet_tx #(.CLOCK(16), .BAUD(1), .GAP_BITS(0)) dut0 (
        .clk(clk), .rst(rst0), .load(load0), .midstate(mid0), .data2(d20),
        .tx(tx0), .busy(busy0), .done(done0), .byte_idx(bi0));

    work_packet_tx #(.CLOCK(16), .BAUD(1), .GAP_BITS(2)) dutg (
        .clk(clk), .rst(rstg), .load(loadg), .midstate(midg), .data2(d2g),
        .tx(txg), .busy(busyg), .done(doneg), .byte_idx(big));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected line level t cycles after the first start-bit cycle of a packet.
    function automatic logic exp_tx(input logic [511:0] p, input int t, input int gap);
        int frame = (10 + gap) * BC;
        int k = t / frame;
        int b = (t % frame) / BC;
        if (b == 0) return 1'b0;
        if (b <= 8) return p[8 * k + b - 1];
        return 1'b1;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32 * i +: 32] = $urandom;
        return r;
    endfunction

    // Called right after load0 was raised at a negedge; watches the whole packet.
    task automatic watch0(input string tag, input logic [511:0] p,
                          input int intr_t, input logic [511:0] p_intr,
                          input bit chain, input logic [511:0] p_next,
                          input int abort_t);
        int frame = 10 * BC;
        int total = 64 * frame;
        int e_tx = 0, e_busy = 0, e_done = 0, e_idx = 0, e_post = 0;
        int done_t = -1;
        bit aborted = 1'b0;
        for (int t = 0; t <= total; t++) begin
            @(negedge clk);
            load0 = 1'b0;
            if (tx0 !== ((t < total) ? exp_tx(p, t, 0) : 1'b1)) e_tx++;
            if (busy0 !== (t < total)) e_busy++;
            if (done0 !== (t == total)) e_done++;
            if (done0 === 1'b1 && done_t < 0) done_t = t;
            if (bi0 !== ((t < total) ? 7'(t / frame) : 7'd0)) e_idx++;
            if (t == intr_t) begin
                load0 = 1'b1;
                {mid0, d20} = p_intr;
            end
            if (t == abort_t) begin
                aborted = 1'b1;
                break;
            end
            if (t == total && chain) begin
                load0 = 1'b1;
                {mid0, d20} = p_next;
            end
        end
        check({tag, "_tx"}, e_tx, 0);
        check({tag, "_busy"}, e_busy, 0);
        check({tag, "_done"}, e_done, 0);
        check({tag, "_byte_idx"}, e_idx, 0);
        if (!aborted) begin
            check({tag, "_done_cycle"}, done_t, total);
        end else begin
            rst0 = 1'b1;
            #1;
            check({tag, "_rst_tx"}, tx0, 1);
            check({tag, "_rst_busy"}, busy0, 0);
            check({tag, "_rst_byte_idx"}, bi0, 0);
            @(negedge clk);
            rst0 = 1'b0;
            for (int i = 0; i < 3 * frame; i++) begin
                @(negedge clk);
                if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) e_post++;
            end
            check({tag, "_after_rst_quiet"}, e_post, 0);
        end
    endtask

    typedef struct {
        logic [7:0] val;
        logic [9:0] frame;  // frame[j] = j-th bit period on the wire, start first
    } vec_t;

    vec_t vecs[6];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            begin : main0
                logic [511:0] pa, pb, pc, pd, pe, px;
                logic [9:0] act;
                int bad;
                vecs[0] = '{8'hA5, 10'b1_10100101_0};
                vecs[1] = '{8'h00, 10'b1_00000000_0};
                vecs[2] = '{8'hFF, 10'b1_11111111_0};
                vecs[3] = '{8'h01, 10'b1_00000001_0};
                vecs[4] = '{8'h80, 10'b1_10000000_0};
                vecs[5] = '{8'h3C, 10'b1_00111100_0};

                #1 rst0 = 1'b1;
                #1;
                check("reset_tx", tx0, 1);
                check("reset_busy", busy0, 0);
                check("reset_done", done0, 0);
                check("reset_byte_idx", bi0, 0);
                @(negedge clk);
                rst0 = 1'b0;
                bad = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) bad++;
                end
                check("idle_quiet", bad, 0);

                foreach (vecs[v]) begin
                    @(negedge clk);
                    load0 = 1'b1;
                    mid0 = '0;
                    d20 = {248'h0, vecs[v].val};
                    @(negedge clk);
                    load0 = 1'b0;
                    repeat (BC / 2) @(negedge clk);
                    for (int j = 0; j < 10; j++) begin
                        act[j] = tx0;
                        repeat (BC) @(negedge clk);
                    end
                    check($sformatf("frame_%02h", vecs[v].val), act, vecs[v].frame);
                    check($sformatf("byte_idx_next_%02h", vecs[v].val), bi0, 1);
                    rst0 = 1'b1;
                    @(negedge clk);
                    rst0 = 1'b0;
                end

                pa = rand512();
                pb = rand512();
                pc = rand512();
                pd = rand512();
                pe = rand512();
                px = rand512();

                @(negedge clk);
                load0 = 1'b1;
                {mid0, d20} = pa;
                watch0("pktA", pa, -1, '0, 1'b0, '0, -1);

                repeat (5) @(negedge clk);
                load0 = 1'b1;
                {mid0, d20} = pb;
                watch0("pktB_ignore_load", pb, 20 * 10 * BC + 50, px, 1'b1, pc, -1);
                watch0("pktC_back_to_back", pc, -1, '0, 1'b0, '0, -1);

                @(negedge clk);
                load0 = 1'b1;
                {mid0, d20} = pd;
                watch0("pktD_abort", pd, -1, '0, 1'b0, '0, 37 * 10 * BC + 3);

                @(negedge clk);
                load0 = 1'b1;
                {mid0, d20} = pe;
                watch0("pktE_restart", pe, -1, '0, 1'b0, '0, -1);
            end
            begin : gap_branch
                logic [511:0] pg;
                int frame, total, e_tx, e_busy, e_done, e_idx, done_t;
                frame = 12 * BC;
                total = 64 * frame;
                e_tx = 0; e_busy = 0; e_done = 0; e_idx = 0; done_t = -1;
                pg = rand512();
                #1 rstg = 1'b1;
                @(negedge clk);
                rstg = 1'b0;
                @(negedge clk);
                loadg = 1'b1;
                {midg, d2g} = pg;
                for (int t = 0; t <= total; t++) begin
                    @(negedge clk);
                    loadg = 1'b0;
                    if (txg !== ((t < total) ? exp_tx(pg, t, 2) : 1'b1)) e_tx++;
                    if (busyg !== (t < total)) e_busy++;
                    if (doneg !== (t == total)) e_done++;
                    if (doneg === 1'b1 && done_t < 0) done_t = t;
                    if (big !== ((t < total) ? 7'(t / frame) : 7'd0)) e_idx++;
                end
                check("gap_tx", e_tx, 0);
                check("gap_busy", e_busy, 0);
                check("gap_done", e_done, 0);
                check("gap_byte_idx", e_idx, 0);
                check("gap_done_cycle", done_t, 64 * 12 * 16);
            end
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
